// File: rtl/timer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : timer_scheduler
// Description : Bus-programmable periodic/one-shot timer with prescaler,
//               sticky completion flag and level interrupt.
// Revision    : 1.0
// ============================================================================
module timer_scheduler #(
    parameter int N = 16,
    parameter int P = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [1:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        tick,
    output logic        irq,
    output logic        running
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_HALT = 2'd2;

    localparam logic [1:0] c_ADDR_CTRL   = 2'd0;
    localparam logic [1:0] c_ADDR_PERIOD = 2'd1;
    localparam logic [1:0] c_ADDR_COUNT  = 2'd2;
    localparam logic [1:0] c_ADDR_STATUS = 2'd3;

    logic [1:0]   r_state;
    logic [1:0]   w_state_next;
    logic         r_enable;
    logic         r_oneshot;
    logic         r_irq_en;
    logic [P-1:0] r_prescale;
    logic [P-1:0] r_psc;
    logic [N-1:0] r_period;
    logic [N-1:0] r_shadow;
    logic [N-1:0] r_count;
    logic         r_done;
    logic         r_tick;
    logic [31:0]  r_rd_data;
    logic [31:0]  w_rd_mux;

    logic w_wr_ctrl;
    logic w_wr_period;
    logic w_clear_done;
    logic w_enable_next;
    logic w_step;
    logic w_wrap;
    logic w_unused_wr;

    // Enable as it will be after this edge, so a CTRL write acts on the FSM immediately
    assign w_wr_ctrl     = wr_en && (addr == c_ADDR_CTRL);
    assign w_wr_period   = wr_en && (addr == c_ADDR_PERIOD);
    assign w_clear_done  = wr_en && (addr == c_ADDR_STATUS) && wr_data[0];
    assign w_enable_next = w_wr_ctrl ? wr_data[0] : r_enable;
    assign w_step        = (r_state == c_ST_RUN) && w_enable_next && (r_psc == r_prescale);
    assign w_wrap        = w_step && (r_count == r_shadow);
    assign w_unused_wr   = ^wr_data;

    assign tick    = r_tick;
    assign rd_data = r_rd_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_enable_next) w_state_next = c_ST_RUN;
            end
            c_ST_RUN: begin
                if (!w_enable_next)           w_state_next = c_ST_IDLE;
                else if (w_wrap && r_oneshot) w_state_next = c_ST_HALT;
            end
            c_ST_HALT: begin
                if (!w_enable_next) w_state_next = c_ST_IDLE;
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        running = (r_state == c_ST_RUN);
        irq     = r_done && r_irq_en;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_enable   <= 1'b0;
            r_oneshot  <= 1'b0;
            r_irq_en   <= 1'b0;
            r_prescale <= '0;
            r_period   <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_enable   <= wr_data[0];
                r_oneshot  <= wr_data[1];
                r_irq_en   <= wr_data[2];
                r_prescale <= wr_data[8 +: P];
            end
            if (w_wr_period) r_period <= wr_data[N-1:0];
        end
    end

    // One-shot completion keeps the count at its terminal value while halted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow <= '0;
            r_count  <= '0;
            r_psc    <= '0;
        end else if (w_state_next == c_ST_IDLE) begin
            r_count <= '0;
            r_psc   <= '0;
        end else if (r_state == c_ST_IDLE) begin
            r_shadow <= r_period;
            r_count  <= '0;
            r_psc    <= '0;
        end else if (r_state == c_ST_RUN) begin
            if (w_step) begin
                r_psc <= '0;
                if (w_wrap) begin
                    if (!r_oneshot) begin
                        r_count  <= '0;
                        r_shadow <= r_period;
                    end
                end else begin
                    r_count <= r_count + {{(N-1){1'b0}}, 1'b1};
                end
            end else begin
                r_psc <= r_psc + {{(P-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_tick <= w_wrap;
            r_done <= w_wrap || (r_done && !w_clear_done);
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (addr)
            c_ADDR_CTRL: begin
                w_rd_mux[0]     = r_enable;
                w_rd_mux[1]     = r_oneshot;
                w_rd_mux[2]     = r_irq_en;
                w_rd_mux[8 +: P] = r_prescale;
            end
            c_ADDR_PERIOD: w_rd_mux[N-1:0] = r_period;
            c_ADDR_COUNT:  w_rd_mux[N-1:0] = r_count;
            default: begin
                w_rd_mux[0] = r_done;
                w_rd_mux[1] = (r_state == c_ST_RUN);
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= w_rd_mux;
        end
    end

endmodule
`default_nettype wire
